// File: rtl/uart_rx_frame_parser_if.sv
// rtl/uart_rx_frame_parser_if.sv - byte-in / payload-stream-out bundle for the UART frame parser
// master is the parser side; slave is the UART receiver plus payload consumer side.
interface uart_rx_frame_parser_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]      rx_data;
    logic            data_ready;
    logic [7:0]      m_data;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;
    logic            frame_ok;
    logic            frame_err;
    logic [1:0]      err_code;
    logic [ADDR_W:0] fifo_level;

    modport master (
        input  rx_data, data_ready, m_ready,
        output m_data, m_last, m_valid, frame_ok, frame_err, err_code, fifo_level
    );

    modport slave (
        output rx_data, data_ready, m_ready,
        input  m_data, m_last, m_valid, frame_ok, frame_err, err_code, fifo_level
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - SOF/LEN/payload/CHK frame parser with commit-on-good-checksum FIFO
// Payload is written speculatively and only made visible when the XOR checksum matches.
module uart_rx_frame_parser #(
    parameter logic [7:0] SOF_BYTE    = 8'h7E,
    parameter int         MAX_LEN     = 32,
    parameter int         FIFO_DEPTH  = 64,
    parameter int         ADDR_W      = 6,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_rx_frame_parser_if.master    bus
);
    localparam int PW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DISCARD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   start_ptr_q, start_ptr_d;
    logic [7:0]      chk_q, chk_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [8:0]      skip_q, skip_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [PW-1:0]   fifo_level_q, fifo_level_d;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [8:0]      head;
    logic [8:0]      wr_word;
    logic            wr_en;
    logic            m_valid;
    logic [PW-1:0]   used;
    logic [PW-1:0]   free;
    logic            tmo_hit;
    logic            dr;
    logic [7:0]      rx;

    assign dr      = bus.data_ready;
    assign rx      = bus.rx_data;
    assign m_valid = (rd_ptr_q != commit_ptr_q);
    assign head    = mem[rd_ptr_q[ADDR_W-1:0]];
    assign used    = wr_ptr_q - rd_ptr_q;
    assign free    = PW'(FIFO_DEPTH) - used;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Head is gated so the output is a clean zero while nothing is committed.
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = m_valid ? head[7:0] : 8'h00;
    assign bus.m_last     = m_valid ? head[8] : 1'b0;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.fifo_level = fifo_level_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        start_ptr_d  = start_ptr_q;
        chk_d        = chk_q;
        remaining_d  = remaining_q;
        skip_d       = skip_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        wr_en        = 1'b0;
        wr_word      = {(remaining_q == 8'd1), rx};

        if (m_valid && bus.m_ready) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (state_q == S_HUNT || dr) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_HUNT: begin
                if (dr && rx == SOF_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (dr) begin
                    if (rx == 8'd0 || rx > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd0;
                        state_d     = S_HUNT;
                    end else if ({1'b0, rx} > 9'(free)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd3;
                        skip_d      = {1'b0, rx} + 9'd1;
                        state_d     = S_DISCARD;
                    end else begin
                        chk_d       = rx;
                        remaining_d = rx;
                        start_ptr_d = wr_ptr_q;
                        state_d     = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    // Nothing written yet for this frame, so there is nothing to roll back.
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd2;
                    state_d     = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (dr) begin
                    wr_en       = 1'b1;
                    wr_ptr_d    = wr_ptr_q + PW'(1);
                    chk_d       = chk_q ^ rx;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = S_CHK;
                    end
                end else if (tmo_hit) begin
                    wr_ptr_d    = start_ptr_q;
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd2;
                    state_d     = S_HUNT;
                end
            end
            S_CHK: begin
                if (dr) begin
                    if (rx == chk_q) begin
                        commit_ptr_d = wr_ptr_q;
                        frame_ok_d   = 1'b1;
                    end else begin
                        wr_ptr_d    = start_ptr_q;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                    end
                    state_d = S_HUNT;
                end else if (tmo_hit) begin
                    wr_ptr_d    = start_ptr_q;
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd2;
                    state_d     = S_HUNT;
                end
            end
            S_DISCARD: begin
                if (dr) begin
                    skip_d = skip_q - 9'd1;
                    if (skip_q == 9'd1) begin
                        state_d = S_HUNT;
                    end
                end else if (tmo_hit) begin
                    state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase

        fifo_level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            start_ptr_q  <= '0;
            chk_q        <= '0;
            remaining_q  <= '0;
            skip_q       <= '0;
            tmo_q        <= '0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            fifo_level_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            start_ptr_q  <= start_ptr_d;
            chk_q        <= chk_d;
            remaining_q  <= remaining_d;
            skip_q       <= skip_d;
            tmo_q        <= tmo_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            fifo_level_q <= fifo_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - directed scoreboard bench for uart_rx_frame_parser
module tb_uart_rx_frame_parser;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_parser_if #(.ADDR_W(6)) bus();

    uart_rx_frame_parser #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_asserts = 0;
    int         n_fail = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    bit         toggle_en = 1'b0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (bus.frame_ok) ok_cnt++;
            if (bus.frame_err) err_cnt++;
            if (bus.m_valid && bus.m_ready) begin
                n_asserts++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected observed=%0h expected=none", {bus.m_last, bus.m_data});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_byte", {23'b0, bus.m_last, bus.m_data}, {23'b0, e});
                end
            end
        end
        @(posedge clk);
        #1;
        if (toggle_en) bus.m_ready = ~bus.m_ready;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data    = b;
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] first,
                              input logic [7:0] step, input logic [7:0] chk_xor);
        logic [7:0] chk;
        logic [7:0] b;
        logic       last;
        chk = len;
        send_byte(8'h7E);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            b    = first + 8'(i) * step;
            last = (i == int'(len) - 1);
            chk  = chk ^ b;
            if (chk_xor == 8'h00) exp_q.push_back({last, b});
            send_byte(b);
        end
        send_byte(chk ^ chk_xor);
    endtask

    task automatic drain(input string tag);
        toggle_en   = 1'b0;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 500 && (exp_q.size() != 0 || bus.m_valid); n++) tick();
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_valid_low"}, {31'b0, bus.m_valid}, 0);
    endtask

    initial begin
        int ok0;
        int err0;
        int n;
        bus.rx_data    = 8'h00;
        bus.data_ready = 1'b0;
        bus.m_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", {31'b0, bus.m_valid}, 0);
        check("rst_m_data", {24'b0, bus.m_data}, 0);
        check("rst_m_last", {31'b0, bus.m_last}, 0);
        check("rst_frame_ok", {31'b0, bus.frame_ok}, 0);
        check("rst_frame_err", {31'b0, bus.frame_err}, 0);
        check("rst_err_code", {30'b0, bus.err_code}, 0);
        check("rst_level", {25'b0, bus.fifo_level}, 0);
        rst_n = 1'b1;
        tick();

        // Good frame 7E 03 11 22 33 03
        bus.m_ready = 1'b1;
        ok0 = ok_cnt;
        send_frame(8'd3, 8'h11, 8'h11, 8'h00);
        drain("t1");
        check("t1_ok_count", ok_cnt - ok0, 1);
        check("t1_level", {25'b0, bus.fifo_level}, 0);

        // Checksum error 7E 02 AA 55 00
        err0 = err_cnt;
        send_frame(8'd2, 8'hAA, 8'hAB, 8'hFD);
        check("t2_err_pulse", {31'b0, bus.frame_err}, 1);
        check("t2_err_code", {30'b0, bus.err_code}, 1);
        check("t2_valid", {31'b0, bus.m_valid}, 0);
        check("t2_level", {25'b0, bus.fifo_level}, 0);
        tick();
        check("t2_err_count", err_cnt - err0, 1);
        check("t2_valid_after", {31'b0, bus.m_valid}, 0);

        // Bad lengths 0 and MAX_LEN+1, then resync
        send_byte(8'h7E);
        send_byte(8'h00);
        check("t3_len0_err", {31'b0, bus.frame_err}, 1);
        check("t3_len0_code", {30'b0, bus.err_code}, 0);
        send_byte(8'h7E);
        check("t3_pulse_width", {31'b0, bus.frame_err}, 0);
        send_byte(8'h21);
        check("t3_len33_err", {31'b0, bus.frame_err}, 1);
        check("t3_len33_code", {30'b0, bus.err_code}, 0);
        ok0 = ok_cnt;
        send_frame(8'd1, 8'h5A, 8'h00, 8'h00);
        drain("t3");
        check("t3_ok_count", ok_cnt - ok0, 1);

        // Timeout mid-payload
        send_byte(8'h7E);
        send_byte(8'h04);
        send_byte(8'h01);
        check("t4_uncommitted_level", {25'b0, bus.fifo_level}, 1);
        check("t4_no_valid", {31'b0, bus.m_valid}, 0);
        n = 0;
        while (!bus.frame_err && n < TMO + 20) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", n, TMO);
        check("t4_err_code", {30'b0, bus.err_code}, 2);
        check("t4_level", {25'b0, bus.fifo_level}, 0);
        check("t4_valid", {31'b0, bus.m_valid}, 0);
        ok0 = ok_cnt;
        send_frame(8'd4, 8'h40, 8'h03, 8'h00);
        drain("t4");
        check("t4_ok_count", ok_cnt - ok0, 1);

        // Overflow with the FIFO full of committed data
        bus.m_ready = 1'b0;
        ok0 = ok_cnt;
        send_frame(8'd32, 8'h01, 8'h01, 8'h00);
        send_frame(8'd32, 8'h80, 8'h01, 8'h00);
        tick();
        check("t5_ok_count", ok_cnt - ok0, 2);
        check("t5_full_level", {25'b0, bus.fifo_level}, 64);
        send_byte(8'h7E);
        send_byte(8'h01);
        check("t5_ovf_err", {31'b0, bus.frame_err}, 1);
        check("t5_ovf_code", {30'b0, bus.err_code}, 3);
        send_byte(8'hAB);
        check("t5_no_second_err", {31'b0, bus.frame_err}, 0);
        send_byte(8'hAA);
        tick();
        check("t5_level_kept", {25'b0, bus.fifo_level}, 64);
        drain("t5");
        check("t5_level_drained", {25'b0, bus.fifo_level}, 0);

        // Reads toggling while the next frame is written
        bus.m_ready = 1'b0;
        send_frame(8'd20, 8'h10, 8'h05, 8'h00);
        toggle_en = 1'b1;
        send_frame(8'd30, 8'hC0, 8'h07, 8'h00);
        drain("t6");
        check("t6_level", {25'b0, bus.fifo_level}, 0);

        // Reset in the middle of a payload
        send_byte(8'h7E);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("t6_partial_level", {25'b0, bus.fifo_level}, 3);
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", {31'b0, bus.m_valid}, 0);
        check("t6_rst_data", {24'b0, bus.m_data}, 0);
        check("t6_rst_last", {31'b0, bus.m_last}, 0);
        check("t6_rst_ok", {31'b0, bus.frame_ok}, 0);
        check("t6_rst_err", {31'b0, bus.frame_err}, 0);
        check("t6_rst_code", {30'b0, bus.err_code}, 0);
        check("t6_rst_level", {25'b0, bus.fifo_level}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        ok0 = ok_cnt;
        send_frame(8'd5, 8'h7E, 8'h00, 8'h00);
        drain("t6r");
        check("t6r_ok_count", ok_cnt - ok0, 1);
        check("t6r_level", {25'b0, bus.fifo_level}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
